// File: rtl/edge_filter_pkg.sv
// Shared types and limits for the sig_edge_filter conditioning stage.
package edge_filter_pkg;

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_CHK_HIGH = 2'd1,
        ST_HIGH     = 2'd2,
        ST_CHK_LOW  = 2'd3
    } filt_state_t;

    localparam int unsigned STABLE_MAX = 255;
    localparam int unsigned STAB_CNT_W = $clog2(STABLE_MAX + 1);

    typedef logic [STAB_CNT_W-1:0] stab_cnt_t;

endpackage

// File: rtl/sig_edge_filter_if.sv
// Bundle of the raw input, control and conditioned outputs of sig_edge_filter.
interface sig_edge_filter_if #(
    parameter int unsigned CNT_W = 8
) ();

    logic             sig_in;
    logic             cnt_clr;
    logic             irq_en;
    logic             irq_ack;
    logic             sig_filt;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] fall_count;
    logic             irq;

    modport master (
        output sig_in, cnt_clr, irq_en, irq_ack,
        input  sig_filt, rise_pulse, fall_pulse, fall_count, irq
    );

    modport slave (
        input  sig_in, cnt_clr, irq_en, irq_ack,
        output sig_filt, rise_pulse, fall_pulse, fall_count, irq
    );

endinterface

// File: rtl/sig_edge_filter_sync_2ff.sv
// Two-flop level synchronizer with asynchronous active-low reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_r;
    logic s2_r;

    // Metastability chain: s1 may go metastable, s2 is the clean copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= d;
            s2_r <= s1_r;
        end
    end

    assign q = s2_r;

endmodule

// File: rtl/sig_edge_filter.sv
// Synchronizes and deglitches a raw level, emitting edge pulses, a saturating
// fall counter and a sticky fall interrupt.
module sig_edge_filter
    import edge_filter_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 3,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    sig_edge_filter_if.slave bus
);

    localparam stab_cnt_t STAB_ONE  = stab_cnt_t'(1);
    localparam stab_cnt_t STAB_LAST = stab_cnt_t'(STABLE_CYCLES - 1);

    logic             sync_s;
    filt_state_t      state_r;
    filt_state_t      state_nxt_s;
    stab_cnt_t        stab_cnt_r;
    stab_cnt_t        stab_cnt_nxt_s;
    logic             rise_acc_s;
    logic             fall_acc_s;
    logic             sig_filt_r;
    logic             sig_filt_nxt_s;
    logic             rise_r;
    logic             fall_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             irq_r;
    logic             irq_nxt_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (bus.sig_in),
        .q     (sync_s)
    );

    // State and stability-count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_LOW;
            stab_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            stab_cnt_r <= stab_cnt_nxt_s;
        end
    end

    // Stability filter: a new level must persist for STABLE_CYCLES samples.
    always_comb begin
        state_nxt_s    = state_r;
        stab_cnt_nxt_s = stab_cnt_r;
        rise_acc_s     = 1'b0;
        fall_acc_s     = 1'b0;
        case (state_r)
            ST_LOW: begin
                if (sync_s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_nxt_s    = ST_HIGH;
                        stab_cnt_nxt_s = '0;
                        rise_acc_s     = 1'b1;
                    end else begin
                        state_nxt_s    = ST_CHK_HIGH;
                        stab_cnt_nxt_s = STAB_ONE;
                    end
                end else begin
                    stab_cnt_nxt_s = '0;
                end
            end
            ST_CHK_HIGH: begin
                if (!sync_s) begin
                    state_nxt_s    = ST_LOW;
                    stab_cnt_nxt_s = '0;
                end else if (stab_cnt_r == STAB_LAST) begin
                    state_nxt_s    = ST_HIGH;
                    stab_cnt_nxt_s = '0;
                    rise_acc_s     = 1'b1;
                end else begin
                    stab_cnt_nxt_s = stab_cnt_r + STAB_ONE;
                end
            end
            ST_HIGH: begin
                if (!sync_s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_nxt_s    = ST_LOW;
                        stab_cnt_nxt_s = '0;
                        fall_acc_s     = 1'b1;
                    end else begin
                        state_nxt_s    = ST_CHK_LOW;
                        stab_cnt_nxt_s = STAB_ONE;
                    end
                end else begin
                    stab_cnt_nxt_s = '0;
                end
            end
            ST_CHK_LOW: begin
                if (sync_s) begin
                    state_nxt_s    = ST_HIGH;
                    stab_cnt_nxt_s = '0;
                end else if (stab_cnt_r == STAB_LAST) begin
                    state_nxt_s    = ST_LOW;
                    stab_cnt_nxt_s = '0;
                    fall_acc_s     = 1'b1;
                end else begin
                    stab_cnt_nxt_s = stab_cnt_r + STAB_ONE;
                end
            end
            default: begin
                state_nxt_s    = ST_LOW;
                stab_cnt_nxt_s = '0;
            end
        endcase
    end

    // Output-side next values; a clear coinciding with a fall still counts it.
    always_comb begin
        sig_filt_nxt_s = sig_filt_r;
        count_nxt_s    = count_r;
        irq_nxt_s      = irq_r;
        if (rise_acc_s) begin
            sig_filt_nxt_s = 1'b1;
        end else if (fall_acc_s) begin
            sig_filt_nxt_s = 1'b0;
        end else begin
            sig_filt_nxt_s = sig_filt_r;
        end
        if (fall_acc_s) begin
            count_nxt_s = bus.cnt_clr ? CNT_W'(1) : sat_inc(count_r);
        end else if (bus.cnt_clr) begin
            count_nxt_s = '0;
        end else begin
            count_nxt_s = count_r;
        end
        if (fall_acc_s && bus.irq_en) begin
            irq_nxt_s = 1'b1;
        end else if (bus.irq_ack) begin
            irq_nxt_s = 1'b0;
        end else begin
            irq_nxt_s = irq_r;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_filt_r <= 1'b0;
            rise_r     <= 1'b0;
            fall_r     <= 1'b0;
            count_r    <= '0;
            irq_r      <= 1'b0;
        end else begin
            sig_filt_r <= sig_filt_nxt_s;
            rise_r     <= rise_acc_s;
            fall_r     <= fall_acc_s;
            count_r    <= count_nxt_s;
            irq_r      <= irq_nxt_s;
        end
    end

    assign bus.sig_filt   = sig_filt_r;
    assign bus.rise_pulse = rise_r;
    assign bus.fall_pulse = fall_r;
    assign bus.fall_count = count_r;
    assign bus.irq        = irq_r;

endmodule

// File: doc/sig_edge_filter.md
Name: sig_edge_filter

Overview:
- Upstream conditioning stage for the falling-edge checker. It takes a raw, possibly asynchronous level `sig_in` and synchronizes it with 2 flops.
- It deglitches the level with a stability filter and produces the clean level `sig_filt`, whose falling edges the checker samples.
- It also emits one-cycle rise/fall pulses, a saturating fall-event counter, and a sticky fall interrupt with an acknowledge handshake.

Parameters:
- STABLE_CYCLES, 3: consecutive synchronized samples of a new level required before it is accepted. Legal range 1..255.
- CNT_W, 8: width of `fall_count`.

Ports:
- clk, input, 1: single clock; all logic on posedge.
- rst, input, 1: asynchronous, active-low reset. Assertion is immediate; release is synchronous to clk.
- sig_in, input, 1: raw level, asynchronous to clk.
- cnt_clr, input, 1: synchronous clear of `fall_count`.
- irq_en, input, 1: enables setting `irq` on an accepted fall.
- irq_ack, input, 1: clears `irq`.
- sig_filt, output, 1: filtered level, registered.
- rise_pulse, output, 1: one-cycle pulse when a rise is accepted.
- fall_pulse, output, 1: one-cycle pulse when a fall is accepted.
- fall_count, output, CNT_W: number of accepted falls, saturating.
- irq, output, 1: sticky fall interrupt.

Behaviour:
- Reset (rst=0), asynchronous:
  - Synchronizer flops s1, s2 = 0; FSM = ST_LOW; stability count = 0.
  - sig_filt = 0, rise_pulse = 0, fall_pulse = 0, fall_count = 0, irq = 0.
  - Reset mid-filter discards the partial count and generates no pulse.
- Synchronizer: s1 <= sig_in; s2 <= s1. The FSM consumes only s2.
- FSM states: ST_LOW, ST_CHK_HIGH, ST_HIGH, ST_CHK_LOW.
  - ST_LOW with s2=1: go to ST_CHK_HIGH with cnt=1. If STABLE_CYCLES=1, go directly to ST_HIGH and accept.
  - ST_CHK_HIGH with s2=1: cnt++. When cnt reaches STABLE_CYCLES, go to ST_HIGH and accept the rise.
  - ST_CHK_HIGH with s2=0: return to ST_LOW, cnt=0, no pulse (glitch rejected).
  - ST_HIGH, ST_CHK_LOW: mirror image for the falling direction.
- Accept rise:
  - sig_filt <= 1 and rise_pulse <= 1 on the same edge.
  - rise_pulse is high for exactly one cycle.
- Accept fall:
  - sig_filt <= 0 and fall_pulse <= 1 for one cycle.
  - fall_count increments, saturating at 2^CNT_W-1; no wrap.
- Latency: if sig_in is first sampled at its new level at edge k and held, sig_filt changes at edge k+STABLE_CYCLES+1.
  - STABLE_CYCLES=3 gives k+4.
  - STABLE_CYCLES=1 gives k+2.
- A pulse of sig_in shorter than STABLE_CYCLES synchronized samples produces no change. Back-to-back accepted edges are at least STABLE_CYCLES cycles apart.
- cnt_clr:
  - cnt_clr=1 gives fall_count <= 0.
  - cnt_clr and an accepted fall on the same edge give fall_count <= 1 (clear first, then count).
- irq handshake:
  - irq <= 1 on an accepted fall when irq_en=1.
  - irq holds until a cycle with irq_ack=1 and no new set.
  - Set and ack on the same edge leave irq=1 (set wins).
  - irq_en=0 does not clear an already pending irq.
- rise_pulse and fall_pulse are never high together.

Decomposition:
- Package edge_filter_pkg:
  - typedef enum logic [1:0] `filt_state_t` {ST_LOW, ST_CHK_HIGH, ST_HIGH, ST_CHK_LOW}.
  - localparam for the maximum STABLE_CYCLES (255), used to size the stability counter at 8 bits.
- Sub-module sync_2ff: the 2-flop synchronizer, asynchronous active-low reset to 0. It is reusable by other stages.
- FSM, counter and irq logic live in sig_edge_filter.

Test Plan:
- Reset, then sig_in=1 at edge 10 and held (STABLE_CYCLES=3):
  - sig_filt=1 and rise_pulse=1 after edge 14.
  - rise_pulse=0 at edge 15.
  - fall_count=0.
- Glitch: sig_in high for 2 cycles only:
  - sig_filt stays 0, rise_pulse never asserts.
  - FSM returns to ST_LOW.
- Four full high/low cycles of 10 clocks each with irq_en=1:
  - Four fall_pulse pulses, fall_count=4, irq=1 after the first fall.
  - irq_ack for one cycle clears irq to 0.
- CNT_W=2, five accepted falls: fall_count sequence 1, 2, 3, 3, 3 (saturates).
- cnt_clr asserted on the same edge as an accepted fall: fall_count=1. irq_ack on the edge of a new fall with irq_en=1: irq stays 1.
- rst driven low while in ST_CHK_HIGH with cnt=2:
  - All outputs 0 immediately (asynchronous reset).
  - After release, a held sig_in=1 needs a full STABLE_CYCLES+1 again before rise_pulse.
